// File: rtl/ampl_scan.sv
// Sweeps FFT output bins through the float32 magnitude unit, stores each
// amplitude and tracks the spectral peak over the sweep.
module ampl_scan #(
  parameter int N_BINS  = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              bin_rd,
  output logic [ADDR_W-1:0] bin_addr,
  input  logic [31:0]       bin_re,
  input  logic [31:0]       bin_im,
  output logic              amp_start,
  output logic [31:0]       amp_x,
  output logic [31:0]       amp_y,
  input  logic [31:0]       amp_result,
  input  logic              amp_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       peak_amp,
  output logic [ADDR_W-1:0] peak_bin
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, READ, CAPT, LAUNCH, WAIT_LOW, WAIT_HIGH, WRITE, FIN
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              waiting;
  logic              expired;
  logic              res_nan;
  logic              res_gt;

  // cnt holds the cycles already spent in the current wait state
  assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign expired = (cnt == CNT_LAST);
  assign res_nan = (wr_data[30:23] == 8'hFF) && (|wr_data[22:0]);
  assign res_gt  = (wr_data[30:0] > peak_amp[30:0]);

  always_comb begin
    state_d   = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    bin_rd    = 1'b0;
    amp_start = 1'b0;
    wr_en     = 1'b0;
    bin_addr  = idx;
    wr_addr   = idx;
    case (state)
      IDLE:      if (start) state_d = READ;
      READ: begin
        bin_rd  = 1'b1;
        state_d = CAPT;
      end
      CAPT:      state_d = LAUNCH;
      LAUNCH: begin
        amp_start = 1'b1;
        state_d   = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!amp_done)   state_d = WAIT_HIGH;
        else if (expired) state_d = FIN;
      end
      WAIT_HIGH: begin
        if (amp_done)     state_d = WRITE;
        else if (expired) state_d = FIN;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = (idx == LAST_BIN) ? FIN : READ;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      amp_x    <= '0;
      amp_y    <= '0;
      wr_data  <= '0;
      peak_amp <= '0;
      peak_bin <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= (waiting && state_d == state) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            error    <= 1'b0;
            peak_amp <= '0;
            peak_bin <= '0;
          end
        end
        CAPT: begin
          amp_x <= bin_re;
          amp_y <= bin_im;
        end
        WAIT_LOW: begin
          if (amp_done && expired) error <= 1'b1;
        end
        WAIT_HIGH: begin
          if (amp_done)     wr_data <= amp_result;
          else if (expired) error   <= 1'b1;
        end
        WRITE: begin
          // NaN never wins; strict compare keeps the lower bin on ties
          if (!res_nan && res_gt) begin
            peak_amp <= wr_data;
            peak_bin <= idx;
          end
          if (idx != LAST_BIN) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ampl_scan.sv
// Randomized self-checking bench for ampl_scan: FFT RAM and magnitude unit
// models, with expected amplitudes and peak derived from real arithmetic.
module tb_ampl_scan;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, error, bin_rd, amp_start, wr_en, amp_done;
  logic [AW-1:0] bin_addr, wr_addr, peak_bin;
  logic [31:0]   bin_re, bin_im, amp_x, amp_y, amp_result, wr_data, peak_amp;

  always #5 clk = ~clk;

  ampl_scan #(.N_BINS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .bin_rd(bin_rd), .bin_addr(bin_addr), .bin_re(bin_re),
    .bin_im(bin_im), .amp_start(amp_start), .amp_x(amp_x), .amp_y(amp_y),
    .amp_result(amp_result), .amp_done(amp_done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .peak_amp(peak_amp),
    .peak_bin(peak_bin)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // float32 <-> real helpers (normal numbers and zero only)
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    if (f[30:0] == 31'd0) return 0.0;
    e11 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e11;
    if (r == 0.0) return 32'd0;
    b   = $realtobits(r);
    e11 = b[62:52] - 11'd896;
    return {b[63], e11[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fi(input int v);
    return r2f(real'(v));
  endfunction

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic [31:0] y);
    real a, b;
    if (is_nan(x) || is_nan(y)) return 32'h7FC00000;
    a = f2r(x);
    b = f2r(y);
    return r2f($sqrt(a * a + b * b));
  endfunction

  // FFT result RAM: one-cycle read latency
  logic [31:0] ram_re [N];
  logic [31:0] ram_im [N];
  always @(posedge clk) begin
    if (bin_rd) begin
      bin_re <= ram_re[bin_addr];
      bin_im <= ram_im[bin_addr];
    end
  end

  // Magnitude unit: busy-low for 12 cycles starting the cycle after amp_start
  bit          hang = 1'b0;
  int          mcnt;
  logic [31:0] mres;
  always @(posedge clk) begin
    if (reset) begin
      amp_done   <= 1'b1;
      amp_result <= 32'd0;
      mcnt       <= 0;
    end else if (amp_start && !hang) begin
      amp_done <= 1'b0;
      mcnt     <= 12;
      mres     <= mag(amp_x, amp_y);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        amp_done   <= 1'b1;
        amp_result <= mres;
      end
    end
  end

  int          wa[$];
  logic [31:0] wd[$];
  int          ndone = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(wr_data);
    end
    if (done) ndone++;
  end

  task automatic set_bin(input int k, input logic [31:0] re, input logic [31:0] im);
    ram_re[k] = re;
    ram_im[k] = im;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {busy, done, error, bin_rd, amp_start, wr_en}, 32'd0);
    check({tag, "_amp_x"}, amp_x, 32'd0);
    check({tag, "_amp_y"}, amp_y, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_peak_amp"}, peak_amp, 32'd0);
    check({tag, "_addrs"}, {bin_addr, wr_addr, peak_bin}, 32'd0);
  endtask

  // One full sweep from the current RAM contents, checked against the reference
  task automatic sweep(input string tag);
    logic [31:0] e [N];
    logic [31:0] pk;
    int          pb, cyc, d0;
    pk = 32'd0;
    pb = 0;
    for (int k = 0; k < N; k++) begin
      e[k] = mag(ram_re[k], ram_im[k]);
      if (!is_nan(e[k]) && e[k][30:0] > pk[30:0]) begin
        pk = e[k];
        pb = k;
      end
    end
    wa.delete();
    wd.delete();
    d0 = ndone;
    pulse_start();
    check({tag, "_busy_on"}, busy, 1'b1);
    check({tag, "_err_clr"}, error, 1'b0);
    wait_done(tag, cyc);
    @(negedge clk);
    check({tag, "_busy_off"}, busy, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_ndone"}, ndone - d0, 1);
    check({tag, "_nwr"}, wa.size(), N);
    for (int k = 0; k < N; k++) begin
      if (k < wa.size()) begin
        check({tag, "_wr_addr"}, wa[k], k);
        check({tag, "_wr_data"}, wd[k], e[k]);
      end
    end
    check({tag, "_peak_amp"}, peak_amp, pk);
    check({tag, "_peak_bin"}, peak_bin, pb);
  endtask

  task automatic random_bins();
    for (int k = 0; k < N; k++) begin
      set_bin(k, fi(int'($urandom_range(100)) - 50), fi(int'($urandom_range(100)) - 50));
      if ($urandom_range(7) == 0) ram_re[k] = 32'h7FC00000;
    end
  endtask

  initial begin
    int cyc, d0;
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < N; k++) set_bin(k, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    reset = 1'b0;

    // Basic sweep with known values
    set_bin(0, 32'h40400000, 32'h40800000);
    set_bin(1, 32'h00000000, 32'h00000000);
    set_bin(2, 32'hC0C00000, 32'h41000000);
    set_bin(3, 32'h3F800000, 32'h00000000);
    sweep("t1");
    if (wd.size() == N) begin
      check("t1_wd0", wd[0], 32'h40A00000);
      check("t1_wd1", wd[1], 32'h00000000);
      check("t1_wd2", wd[2], 32'h41200000);
      check("t1_wd3", wd[3], 32'h3F800000);
    end
    check("t1_peak_const", peak_amp, 32'h41200000);
    check("t1_peak_bin_const", peak_bin, 2);

    // Tie between bins 1 and 3
    set_bin(0, fi(1), fi(1));
    set_bin(1, fi(3), fi(4));
    set_bin(2, fi(0), fi(2));
    set_bin(3, fi(4), fi(3));
    sweep("t2");
    check("t2_tie_bin", peak_bin, 1);

    // NaN result is stored but never becomes the peak
    set_bin(0, 32'h7FC00000, fi(0));
    set_bin(1, fi(2), fi(0));
    set_bin(2, fi(0), fi(-2));
    set_bin(3, fi(-2), fi(0));
    sweep("t6");
    if (wd.size() == N) check("t6_nan_wr", wd[0], 32'h7FC00000);
    check("t6_peak", peak_amp, 32'h40000000);
    check("t6_peak_bin", peak_bin, 1);

    for (int r = 0; r < 6; r++) begin
      random_bins();
      sweep("rnd");
    end

    // Magnitude unit never accepts the job
    hang = 1'b1;
    random_bins();
    wa.delete();
    wd.delete();
    d0 = ndone;
    pulse_start();
    wait_done("t3", cyc);
    check("t3_latency", (cyc >= TO + 2 && cyc <= TO + 5), 1'b1);
    check("t3_error", error, 1'b1);
    @(negedge clk);
    check("t3_ndone", ndone - d0, 1);
    check("t3_nwr", wa.size(), 0);
    check("t3_error_sticky", error, 1'b1);
    hang = 1'b0;
    sweep("t3b");

    // start held high through the sweep and into IDLE
    random_bins();
    wa.delete();
    wd.delete();
    d0 = ndone;
    @(negedge clk) start = 1'b1;
    wait_done("t5a", cyc);
    @(negedge clk);
    check("t5_idle", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t5_restart", busy, 1'b1);
    check("t5_ndone1", ndone - d0, 1);
    check("t5_nwr1", wa.size(), N);
    wait_done("t5b", cyc);
    @(negedge clk);
    check("t5_ndone2", ndone - d0, 2);
    check("t5_nwr2", wa.size(), 2 * N);

    // Reset while waiting on bin 2
    random_bins();
    wa.delete();
    wd.delete();
    pulse_start();
    cyc = 0;
    while (wa.size() < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_two_writes", wa.size(), 2);
    cyc = 0;
    while (amp_done !== 1'b0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_unit_busy", amp_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    d0 = ndone;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("t4_rst");
    reset = 1'b0;
    @(negedge clk);
    check("t4_no_done", ndone - d0, 0);
    check("t4_no_wr", wa.size(), 2);
    sweep("t4b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ampl_scan.md
Name: ampl_scan

Overview:
- Upstream sequencer for the float32 magnitude unit: walks the FFT output RAM bin by bin, presents each (re, im) pair as x/y, starts one magnitude computation per bin, and writes each result into the amplitude RAM.
- Tracks the spectral peak (largest amplitude and its bin index) during the sweep.
- Single-owner controller between the FFT result memory and the magnitude unit; one sweep per start request.

Parameters:
- N_BINS, 64, bins swept per run (2..2^ADDR_W).
- ADDR_W, 6, bin address width.
- TIMEOUT, 1023, max cycles allowed in either wait state before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  sweep request, sampled in IDLE only
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse at sweep end (normal or aborted)
- error  out  1  sticky timeout flag, cleared on the next accepted start
- bin_rd  out  1  FFT RAM read strobe
- bin_addr  out  ADDR_W  FFT RAM address
- bin_re  in  32  float32 real part, valid 1 cycle after bin_rd
- bin_im  in  32  float32 imaginary part, same timing
- amp_start  out  1  one-cycle start to magnitude unit
- amp_x  out  32  held x operand
- amp_y  out  32  held y operand
- amp_result  in  32  float32 magnitude
- amp_done  in  1  magnitude unit idle/done level (high idle, low while computing)
- wr_en  out  1  amplitude RAM write strobe
- wr_addr  out  ADDR_W  amplitude RAM address
- wr_data  out  32  amplitude written
- peak_amp  out  32  largest amplitude of last sweep
- peak_bin  out  ADDR_W  bin of peak_amp

Behaviour:
- Reset (sync, active-high): state IDLE; bin index 0. Outputs busy, done, error, bin_rd, amp_start and wr_en are 0. amp_x, amp_y, wr_data and peak_amp are 0x00000000. bin_addr, wr_addr and peak_bin are 0. The timeout counter is 0.
- Reset mid-sweep: abandon immediately. No done pulse. Amplitude RAM contents are left as written.
- States:
  - IDLE: on start=1 go to READ; index=0, error=0, peak_amp=0, peak_bin=0. start while busy is ignored.
  - READ (1 cycle): bin_rd=1, bin_addr=index. Go to CAPT.
  - CAPT (1 cycle): latch bin_re→amp_x and bin_im→amp_y. Go to LAUNCH.
  - LAUNCH (1 cycle): amp_start=1. Go to WAIT_LOW.
  - WAIT_LOW: wait for amp_done=0 (unit accepted the job), then go to WAIT_HIGH.
  - WAIT_HIGH: wait for amp_done=1, then go to WRITE. amp_result is sampled in the cycle amp_done is first seen high.
  - WRITE (1 cycle): wr_en=1, wr_addr=index, wr_data=amp_result. Peak update as below. If index==N_BINS-1 go to FIN; else index+1 and go to READ.
  - FIN (1 cycle): done=1, busy=0 next cycle. Go to IDLE.
- amp_x and amp_y stay stable from CAPT until the next CAPT; the unit may resample them at any time.
- Timeout counter:
  - Counts cycles spent in WAIT_LOW/WAIT_HIGH and resets on each state change.
  - Reaching TIMEOUT sets error=1 and jumps to FIN. No write is made for that bin, and the peak is unchanged.
- Peak update:
  - Amplitudes are non-negative, so compare bits[30:0] as unsigned.
  - Update only if strictly greater than peak_amp; ties keep the lower bin.
  - NaN (exp=0xFF, mantissa≠0) is written to RAM but never becomes peak. +Inf may become peak.
- Per-bin cycle count: 5 + unit latency + wait cycles. Bins are strictly serial; no overlap.
- peak_amp/peak_bin hold their values after FIN until the next accepted start.

Test Plan:
- Use a behavioural magnitude model: amp_done drops 1 cycle after amp_start and returns high 12 cycles later.
- Test 1: N_BINS=4, bins (3,4), (0,0), (−6,8), (1,0), i.e. re 0x40400000/0x00000000/0xC0C00000/0x3F800000. Start → wr_data sequence 0x40A00000, 0x00000000, 0x41200000, 0x3F800000 at addrs 0..3; peak_amp=0x41200000, peak_bin=2; exactly one done pulse; error=0.
- Test 2: bins 1 and 3 both give 5.0 → peak_bin=1 (tie keeps lower).
- Test 3: the model never drops amp_done → after TIMEOUT cycles error=1, done pulse, no wr_en for bin 0. The next start clears error.
- Test 4: reset asserted in WAIT_HIGH of bin 2 → next cycle all outputs at reset values, no done. A fresh start sweeps from bin 0.
- Test 5: start held high for the whole sweep, plus extra start pulses while busy → exactly one sweep, one done. A start the cycle after done begins a new sweep.
- Test 6: a bin yields NaN 0x7FC00000 and the others yield 2.0 → NaN is written to RAM, peak_amp=0x40000000.
